// File: rtl/mc_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_io_pkg
// Brief    : Shared types and defaults for the operator-panel Wishbone slave.
// Revision : 1.0 - initial release
// ============================================================================
package mc_io_pkg;

    // Default bus geometry and synchroniser depth
    localparam int c_DW_DEFAULT          = 32;
    localparam int c_AW_DEFAULT          = 32;
    localparam int c_SYNC_STAGES_DEFAULT = 2;

    // Panel transaction state
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } mc_state_t;

    // A lever event is any level change between two consecutive samples
    function automatic logic lever_toggled(input logic cur, input logic prev);
        return cur ^ prev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_sync.sv
`default_nettype none
// ============================================================================
// Module   : mc_sync
// Brief    : Multi-flop synchroniser for asynchronous operator inputs.
//            Every bit passes through STAGES flops; all stages clear on reset.
// Revision : 1.0 - initial release
// ============================================================================
module mc_sync
    import mc_io_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = c_SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Stage 0 sits at the asynchronous boundary; the last stage is the output
    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    // Shift the sampled value one stage deeper each clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mc_wb_panel.sv
`default_nettype none
// ============================================================================
// Module   : mc_wb_panel
// Brief    : Wishbone slave answered by a human operator. A bus request is
//            latched onto the lights; the operator sets the read-data
//            switches and flips the acknowledge lever to complete it. An
//            optional timeout auto-acknowledges with zero data.
// Revision : 1.0 - initial release
// ============================================================================
module mc_wb_panel
    import mc_io_pkg::*;
#(
    parameter int DW          = c_DW_DEFAULT,
    parameter int AW          = c_AW_DEFAULT,
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT,
    parameter int TIMEOUT     = 0
) (
    input  logic            clk,
    input  logic            i_rst,
    // Wishbone slave port
    input  logic            i_wb_cyc,
    input  logic [AW-1:0]   i_wb_adr,
    input  logic [DW-1:0]   i_wb_dat,
    input  logic [DW/8-1:0] i_wb_sel,
    input  logic            i_wb_we,
    output logic [DW-1:0]   o_wb_rdt,
    output logic            o_wb_ack,
    // Operator switches (asynchronous)
    input  logic [DW-1:0]   i_sw_rdt,
    input  logic            i_sw_ack,
    // Lights
    output logic [AW-1:0]   o_lt_adr,
    output logic [DW-1:0]   o_lt_dat,
    output logic [DW/8-1:0] o_lt_sel,
    output logic            o_lt_we,
    output logic            o_lt_pending,
    output logic            o_timeout
);

    mc_state_t       r_state;
    logic [AW-1:0]   r_lt_adr;
    logic [DW-1:0]   r_lt_dat;
    logic [DW/8-1:0] r_lt_sel;
    logic            r_lt_we;
    logic            r_lt_pending;
    logic            r_ack;
    logic [DW-1:0]   r_rdt;
    logic            r_timeout;

    logic            w_ack_sync;
    logic [DW-1:0]   w_rdt_sync;
    logic            r_ack_dly;
    logic            w_toggle;
    logic            w_pend_entry;
    logic            w_timeout_hit;

    // ------------------------------------------------------------------------
    // Operator input synchronisers
    // ------------------------------------------------------------------------
    mc_sync #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync_ack (
        .clk (clk),
        .rst (i_rst),
        .i_d (i_sw_ack),
        .o_q (w_ack_sync)
    );

    mc_sync #(
        .WIDTH  (DW),
        .STAGES (SYNC_STAGES)
    ) u_sync_rdt (
        .clk (clk),
        .rst (i_rst),
        .i_d (i_sw_rdt),
        .o_q (w_rdt_sync)
    );

    // One-cycle delayed copy of the synchronised lever for edge detection
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack_dly <= 1'b0;
        end else begin
            r_ack_dly <= w_ack_sync;
        end
    end

    // The toggle pulse lasts one cycle whatever state we are in; only the
    // PENDING branch of the FSM acts on it, so events elsewhere simply vanish.
    assign w_toggle     = lever_toggled(w_ack_sync, r_ack_dly);
    assign w_pend_entry = (r_state == ST_IDLE) && i_wb_cyc;

    // ------------------------------------------------------------------------
    // Optional auto-acknowledge timer
    // ------------------------------------------------------------------------
    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

            logic [c_CNT_W-1:0] r_cnt;

            // Count PENDING cycles, restarting from zero on every new capture
            always_ff @(posedge clk or posedge i_rst) begin
                if (i_rst) begin
                    r_cnt <= '0;
                end else if (w_pend_entry) begin
                    r_cnt <= '0;
                end else if (r_state == ST_PENDING) begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            assign w_timeout_hit = (r_state == ST_PENDING) && (r_cnt == c_CNT_LAST);
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Transaction FSM with registered outputs
    // ------------------------------------------------------------------------
    // Capture, wait for the operator (or the timer), then pulse ack once
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_lt_adr     <= '0;
            r_lt_dat     <= '0;
            r_lt_sel     <= '0;
            r_lt_we      <= 1'b0;
            r_lt_pending <= 1'b0;
            r_ack        <= 1'b0;
            r_rdt        <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_rdt <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pend_entry) begin
                        r_lt_adr     <= i_wb_adr;
                        r_lt_dat     <= i_wb_dat;
                        r_lt_sel     <= i_wb_sel;
                        r_lt_we      <= i_wb_we;
                        r_lt_pending <= 1'b1;
                        r_state      <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    // Priority: master abort, then operator lever, then timer
                    if (!i_wb_cyc) begin
                        r_lt_pending <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (w_toggle) begin
                        r_lt_pending <= 1'b0;
                        r_ack        <= 1'b1;
                        r_rdt        <= r_lt_we ? '0 : w_rdt_sync;
                        r_state      <= ST_ACK;
                    end else if (w_timeout_hit) begin
                        r_lt_pending <= 1'b0;
                        r_ack        <= 1'b1;
                        r_timeout    <= 1'b1;
                        r_state      <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_lt_pending <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wb_ack     = r_ack;
    assign o_wb_rdt     = r_rdt;
    assign o_lt_adr     = r_lt_adr;
    assign o_lt_dat     = r_lt_dat;
    assign o_lt_sel     = r_lt_sel;
    assign o_lt_we      = r_lt_we;
    assign o_lt_pending = r_lt_pending;
    assign o_timeout    = r_timeout;

endmodule
`default_nettype wire
